// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if: valid/ready operation and result channels of pipelined_shifter
// master: issues operations (in_*) and consumes results (out_ready); slave: the shifter.
// in_valid/in_ready/in_op/in_operand/in_shamt: operation channel.
// out_valid/out_ready/out_result/out_illegal: result channel.
// out_zero/out_carry exist only when SHIFTER_FLAGS_EN is defined.
interface pipelined_shifter_if #(parameter int WIDTH = 32);
  localparam int SHAMT_W = $clog2(WIDTH);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [WIDTH-1:0]   in_operand;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               out_illegal;
`ifdef SHIFTER_FLAGS_EN
  logic               out_zero;
  logic               out_carry;
`endif
  modport master (
    output in_valid, in_op, in_operand, in_shamt, out_ready,
    input  in_ready, out_valid, out_result, out_illegal
`ifdef SHIFTER_FLAGS_EN
    , input out_zero, out_carry
`endif
  );
  modport slave (
    input  in_valid, in_op, in_operand, in_shamt, out_ready,
    output in_ready, out_valid, out_result, out_illegal
`ifdef SHIFTER_FLAGS_EN
    , output out_zero, out_carry
`endif
  );
endinterface

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: STAGES-deep logarithmic barrel shifter (SHL/SHR/SHRA/ROL/ROR) with valid/ready
// Ports: clk, rst_n (async active-low), bus (pipelined_shifter_if.slave).
// Optional SHIFTER_FLAGS_EN adds out_zero/out_carry on the bus.
module pipelined_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  // stage that owns barrel level k; earlier stages take the extra levels
  function automatic int stg(input int k);
    int c = 0;
    int r = 0;
    for (int s = 0; s < STAGES; s++) begin
      c += SHAMT_W / STAGES + ((s < SHAMT_W % STAGES) ? 1 : 0);
      if (k >= c) r = s + 1;
    end
    return r;
  endfunction
  function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] d, input logic [2:0] op, input int k);
    int a;
    logic [WIDTH-1:0] sra;
    a = 1 << k;
    sra = $signed(d) >>> a;
    return op == 3'd0 ? d << a :
           op == 3'd1 ? d >> a :
           op == 3'd2 ? sra :
           op == 3'd3 ? (d << a) | (d >> (WIDTH - a)) :
           op == 3'd4 ? (d >> a) | (d << (WIDTH - a)) : d;
  endfunction
`ifdef SHIFTER_FLAGS_EN
  // last bit pushed out by one level; rotates are resolved from the final result
  function automatic logic cb(input logic [WIDTH-1:0] d, input logic [2:0] op, input int k, input logic c);
    int a;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] l;
    a = 1 << k;
    h = d >> (WIDTH - a);
    l = d >> (a - 1);
    return op == 3'd0 ? h[0] : (op == 3'd1 || op == 3'd2) ? l[0] : c;
  endfunction
  logic r_c [STAGES];
  logic w_c [STAGES];
  logic r_z;
`endif
  logic               r_v  [STAGES];
  logic [2:0]         r_op [STAGES];
  logic [SHAMT_W-1:0] r_sh [STAGES];
  logic [WIDTH-1:0]   r_d  [STAGES];
  logic               w_v  [STAGES];
  logic [2:0]         w_op [STAGES];
  logic [SHAMT_W-1:0] w_sh [STAGES];
  logic [WIDTH-1:0]   w_d  [STAGES];
  logic               w_adv;
  assign w_adv           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready    = w_adv;
  assign bus.out_valid   = r_v[STAGES-1];
  assign bus.out_result  = r_d[STAGES-1];
  assign bus.out_illegal = r_op[STAGES-1] > 3'd4;
`ifdef SHIFTER_FLAGS_EN
  assign bus.out_zero    = r_z;
  assign bus.out_carry   = r_c[STAGES-1];
`endif
  always_comb begin
    w_v[0]  = bus.in_valid;
    w_op[0] = bus.in_op;
    w_sh[0] = bus.in_shamt;
    w_d[0]  = bus.in_operand;
`ifdef SHIFTER_FLAGS_EN
    w_c[0]  = 1'b0;
`endif
    for (int s = 1; s < STAGES; s++) begin
      w_v[s]  = r_v[s-1];
      w_op[s] = r_op[s-1];
      w_sh[s] = r_sh[s-1];
      w_d[s]  = r_d[s-1];
`ifdef SHIFTER_FLAGS_EN
      w_c[s]  = r_c[s-1];
`endif
    end
    for (int s = 0; s < STAGES; s++) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (stg(k) == s && w_sh[s][k]) begin
`ifdef SHIFTER_FLAGS_EN
          w_c[s] = cb(w_d[s], w_op[s], k, w_c[s]);
`endif
          w_d[s] = lvl(w_d[s], w_op[s], k);
        end
      end
`ifdef SHIFTER_FLAGS_EN
      if (s == STAGES - 1)
        w_c[s] = w_sh[s] == '0 ? 1'b0 : w_op[s] == 3'd3 ? w_d[s][0] : w_op[s] == 3'd4 ? w_d[s][WIDTH-1] : w_c[s];
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_v[s]  <= 1'b0;
        r_op[s] <= '0;
        r_sh[s] <= '0;
        r_d[s]  <= '0;
`ifdef SHIFTER_FLAGS_EN
        r_c[s]  <= 1'b0;
`endif
      end
`ifdef SHIFTER_FLAGS_EN
      r_z <= 1'b0;
`endif
    end else if (w_adv) begin
      for (int s = 0; s < STAGES; s++) begin
        r_v[s]  <= w_v[s];
        r_op[s] <= w_op[s];
        r_sh[s] <= w_sh[s];
        r_d[s]  <= w_d[s];
`ifdef SHIFTER_FLAGS_EN
        r_c[s]  <= w_c[s];
`endif
      end
`ifdef SHIFTER_FLAGS_EN
      r_z <= w_d[STAGES-1] == '0;
`endif
    end
endmodule
